amm_write_master: RTL
=====================

# amm_write_master

Avalon-MM write master sitting between `user_logic` and the SDRAM controller fabric inside the SoC. It is the responder end of the user write-control interface (`fixed_location`/`write_base`/`write_length`/`go`/`done`) and the user write buffer (`write_buffer`/`buffer_input_data`/`buffer_full`). It buffers user words in a local FIFO and drains them as single-beat Avalon-MM writes starting at a byte base address, for a byte length.

## Interface
- `ADDRESSWIDTH`, default 8: byte address width and length width.
- `DATAWIDTH`, default 32: data word width. `BYTES = DATAWIDTH/8`.
- `FIFO_DEPTH`, default 8: FIFO entries; power of two.
- `FIFO_DEPTH_LOG2`, default 3: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low reset.
- `control_fixed_location`  in  1  1 = every beat goes to the base address.
- `control_write_base`  in  ADDRESSWIDTH  byte start address; low log2(BYTES) bits ignored.
- `control_write_length`  in  ADDRESSWIDTH  transfer length in bytes; low log2(BYTES) bits ignored.
- `control_go`  in  1  start pulse; sampled only when idle.
- `control_done`  out  1  level; high when no transfer is in progress.
- `user_write_buffer`  in  1  push `user_buffer_data` into the FIFO this cycle.
- `user_buffer_data`  in  DATAWIDTH  push data.
- `user_buffer_full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `master_address`  out  ADDRESSWIDTH  Avalon byte address.
- `master_write`  out  1  Avalon write request.
- `master_byteenable`  out  BYTES  constant all ones.
- `master_writedata`  out  DATAWIDTH  FIFO head; 0 when the FIFO is empty.
- `master_waitrequest`  in  1  Avalon slave stall.

## Operation
- FSM states:
  - IDLE → WRITE on `control_go` when the aligned length ≠ 0. At that point latch `address = base & ~(BYTES-1)`, `remaining = length & ~(BYTES-1)`, and `fixed`.
  - `control_go` with aligned length 0: stay in IDLE; `control_done` stays 1.
  - `control_go` while in WRITE: ignored. Latched values are unaffected.
  - WRITE → IDLE on acceptance of the last beat, i.e. when `remaining == BYTES` at accept.
- `master_write = (state == WRITE) && !fifo_empty`.
- Beat accepted on `master_write && !master_waitrequest`. On accept:
  - pop the FIFO;
  - `remaining -= BYTES`;
  - `address += BYTES` unless `fixed`.
- Address arithmetic is modulo 2^ADDRESSWIDTH; it wraps 0xFC → 0x00.
- While `master_write` is high and `master_waitrequest` is high, `master_address` and `master_writedata` hold stable. `master_write` cannot fall without an accept.
- FIFO:
  - Show-ahead. Pushes are accepted in any state, so prefill before `go` is allowed.
  - Push while full is dropped, even if a pop occurs in the same cycle. Contents and count are unchanged.
  - Push and pop in the same non-full, non-empty cycle: count is unchanged and order is preserved.
  - Push and pop when count = 1: the new word becomes the head.
- FIFO underrun during WRITE is legal. `master_write` drops and the transfer resumes when data arrives. `remaining` is unchanged.
- Words left in the FIFO after a transfer completes remain queued for the next transfer.
- `control_done = (state == IDLE)`.

## Timing
- Reset values:
  - `control_done` = 1
  - `user_buffer_full` = 0
  - `master_write` = 0
  - `master_address` = 0
  - `master_writedata` = 0
  - `master_byteenable` = all ones
  - FIFO empty, state IDLE.
- Reset mid-transfer: outputs go to their reset values immediately (asynchronous). The FIFO is flushed and the transfer is abandoned.
- `control_go` sampled at edge N:
  - `control_done` falls after N;
  - `master_address` shows the base after N;
  - the first `master_write` is asserted in cycle N+1 if the FIFO is non-empty.
- Push at edge N into an empty FIFO: data is on `master_writedata` in cycle N+1. It is writable in N+1 if in WRITE.
- `user_buffer_full` is registered from count and changes the cycle after the push or pop that causes it.
- With zero wait states and FIFO never empty: one beat per cycle, so k beats take k cycles.
- Last beat accepted at edge M: `control_done` = 1 and `master_write` = 0 from M onward.

## Test plan
- **Reset:** assert `reset`=0 mid-sim with garbage inputs → outputs at their reset values in the same cycle. After release, `control_done`=1.
- **Basic burst:** prefill 0x11111111, 0x22222222, 0x33333333, 0x44444444; go with base 0x10, len 16, waitrequest 0 → writes to 0x10/0x14/0x18/0x1C in 4 consecutive cycles with matching data. `control_done` is low exactly from the cycle after go until after the 4th beat.
- **Stall:** same transfer with waitrequest high 3 cycles on beat 2 → address 0x14 and data 0x22222222 held stable; exactly 4 accepts; no duplicates.
- **Fixed and wrap:** fixed=1, base 0x40, len 12 → 3 writes all to 0x40. Then fixed=0, base 0xF8, len 16 → 0xF8, 0xFC, 0x00, 0x04.
- **Full/overflow:** push 9 words 1..9 with the FIFO idle → `user_buffer_full`=1 after the 8th push, word 9 dropped. Go with len 32 → data 1..8 in order, then done.
- **Underrun and abort:** go with len 16 and empty FIFO → `master_write` stays 0. Push one word every 3 cycles → one beat each, then done. Repeat the transfer and pull `reset` low after beat 2 → done=1, FIFO empty, `master_write`=0.

Source files
------------

// File: rtl/amm_write_master.sv
// rtl/amm_write_master.sv - Avalon-MM single-beat write master fed by a show-ahead FIFO
module amm_write_master #(
    parameter int ADDRESSWIDTH    = 8,
    parameter int DATAWIDTH       = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]   control_write_base,
    input  logic [ADDRESSWIDTH-1:0]   control_write_length,
    input  logic                      control_go,
    output logic                      control_done,
    input  logic                      user_write_buffer,
    input  logic [DATAWIDTH-1:0]      user_buffer_data,
    output logic                      user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]   master_address,
    output logic                      master_write,
    output logic [DATAWIDTH/8-1:0]    master_byteenable,
    output logic [DATAWIDTH-1:0]      master_writedata,
    input  logic                      master_waitrequest
);
    localparam int BYTES = DATAWIDTH / 8;
    localparam logic [ADDRESSWIDTH-1:0]    STEP       = ADDRESSWIDTH'(BYTES);
    localparam logic [ADDRESSWIDTH-1:0]    ALIGN_MASK = ~(ADDRESSWIDTH'(BYTES - 1));
    localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH      = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                      state;
    logic [DATAWIDTH-1:0]        mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
    logic [FIFO_DEPTH_LOG2:0]    count;
    logic [FIFO_DEPTH_LOG2:0]    count_next;
    logic [ADDRESSWIDTH-1:0]     address;
    logic [ADDRESSWIDTH-1:0]     remaining;
    logic                        fixed;
    logic                        full_r;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic [ADDRESSWIDTH-1:0]     aligned_base;
    logic [ADDRESSWIDTH-1:0]     aligned_length;

    assign fifo_empty     = (count == '0);
    // Fullness is judged on the current count, so a push into a full FIFO is dropped even alongside a pop.
    assign push           = user_write_buffer && (count != DEPTH);
    assign pop            = master_write && !master_waitrequest;
    assign aligned_base   = control_write_base & ALIGN_MASK;
    assign aligned_length = control_write_length & ALIGN_MASK;

    assign master_write      = (state == WRITE) && !fifo_empty;
    assign master_address    = address;
    assign master_byteenable = '1;
    assign master_writedata  = fifo_empty ? '0 : mem[rd_ptr];
    assign control_done      = (state == IDLE);
    assign user_buffer_full  = full_r;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= user_buffer_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            address   <= '0;
            remaining <= '0;
            fixed     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            full_r    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_next;
            full_r <= (count_next == DEPTH);

            case (state)
                IDLE: begin
                    if (control_go && aligned_length != '0) begin
                        state     <= WRITE;
                        address   <= aligned_base;
                        remaining <= aligned_length;
                        fixed     <= control_fixed_location;
                    end
                end
                WRITE: begin
                    if (pop) begin
                        remaining <= remaining - STEP;
                        if (!fixed) begin
                            address <= address + STEP;
                        end
                        if (remaining == STEP) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
